// File: rtl/lms_weight_update_if.sv
// ----------------------------------------------------------------------------
// lms_weight_update_if
//   Bundle of the sample handshake, the adaptation results and the debug view
//   of the lms_weight_update stage.
//
//   Handshake: a sample transfers on a rising clk edge where in_valid and
//   in_ready are both 1. The source holds the data stable while in_valid=1
//   and in_ready=0. out_valid is a single-cycle pulse with no back-pressure:
//   out_a_hat/out_b_hat/out_err/converged are valid while it is high and hold
//   their values afterwards.
//
//   Signals (direction seen from the slave = the adaptation stage):
//     in_valid, in_x_last, in_y_last, in_y_current, in_y_hat_current : in
//     freeze (only when LMS_FREEZE_EN is defined)                    : in
//     in_ready, out_a_hat, out_b_hat, out_err, out_valid, converged  : out
//     fsm_state : out, debug view of the controller state
//   Modports: master (sample source / observer), slave (the stage).
//   Optional feature macro: LMS_FREEZE_EN
// ----------------------------------------------------------------------------
interface lms_weight_update_if #(
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x_last;
    logic signed [DW-1:0] in_y_last;
    logic signed [DW-1:0] in_y_current;
    logic signed [DW-1:0] in_y_hat_current;
    logic signed [DW-1:0] out_a_hat;
    logic signed [DW-1:0] out_b_hat;
    logic signed [DW-1:0] out_err;
    logic                 out_valid;
    logic                 converged;
    logic [1:0]           fsm_state;
`ifdef LMS_FREEZE_EN
    logic                 freeze;
`endif

    modport master (
`ifdef LMS_FREEZE_EN
        output freeze,
`endif
        output in_valid, in_x_last, in_y_last, in_y_current, in_y_hat_current,
        input  in_ready, out_a_hat, out_b_hat, out_err, out_valid, converged,
        input  fsm_state
    );

    modport slave (
`ifdef LMS_FREEZE_EN
        input  freeze,
`endif
        input  in_valid, in_x_last, in_y_last, in_y_current, in_y_hat_current,
        output in_ready, out_a_hat, out_b_hat, out_err, out_valid, converged,
        output fsm_state
    );
endinterface

// File: rtl/lms_weight_update.sv
// ----------------------------------------------------------------------------
// lms_weight_update
//   Adaptation stage of the LMS loop. For each accepted sample it computes
//   e = sat(y - y_hat), the products e*y_last and e*x_last, and moves the
//   coefficient estimates by mu times those products (mu = 2^-MU_SHIFT,
//   arithmetic shift, floor toward -inf). It also tracks how many consecutive
//   samples had |e| <= CONV_TH and raises converged after CONV_CNT of them.
//
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous reset, active-low
//     bus : lms_weight_update_if.slave (handshake, sample, results, debug)
//
//   Controller: IDLE -> ERR -> MUL -> UPD -> IDLE, one sample per 4 cycles.
//   Results and out_valid appear after the third edge following acceptance.
//
//   Optional feature macro: LMS_FREEZE_EN
//     Adds bus.freeze; while it is 1 in UPD the coefficients hold, but
//     out_err, out_valid and the convergence counter still update.
// ----------------------------------------------------------------------------
module lms_weight_update #(
    parameter int DW       = 8,
    parameter int MU_SHIFT = 3,
    parameter int CONV_TH  = 1,
    parameter int CONV_CNT = 8
) (
    input logic               clk,
    input logic               rst,
    lms_weight_update_if.slave bus
);
    localparam int PW = 2 * DW;      // product width
    localparam int SW = 2 * DW + 1;  // headroom for sums before saturation
    localparam int CW = $clog2(CONV_CNT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ERR  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_UPD  = 2'd3;

    localparam logic signed [SW-1:0] SAT_MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]           state;
    logic signed [DW-1:0] x_r, yl_r, y_r, yh_r;
    logic signed [DW-1:0] e_r, a_r, b_r;
    logic signed [PW-1:0] pa_r, pb_r;
    logic [CW-1:0]        cnt_r;
    logic                 conv_r;
    logic                 valid_r;

    // Clamp a wide signed value into the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DW-1:0];
        if (v < SAT_MIN) return SAT_MIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    logic signed [SW-1:0] diff;
    logic signed [PW-1:0] e_w, yl_w, x_w;
    logic signed [PW-1:0] pa_sh, pb_sh;
    logic signed [SW-1:0] a_sum, b_sum;
    logic signed [DW:0]   e_ext, e_abs;
    logic                 near;
    logic [CW-1:0]        cnt_next;
    logic                 adapt;

`ifdef LMS_FREEZE_EN
    assign adapt = !bus.freeze;
`else
    assign adapt = 1'b1;
`endif

    always_comb begin
        diff  = $signed({{(SW-DW){y_r[DW-1]}}, y_r}) - $signed({{(SW-DW){yh_r[DW-1]}}, yh_r});
        e_w   = $signed({{DW{e_r[DW-1]}}, e_r});
        yl_w  = $signed({{DW{yl_r[DW-1]}}, yl_r});
        x_w   = $signed({{DW{x_r[DW-1]}}, x_r});
        // Arithmetic shift of a two's complement value floors toward -inf.
        pa_sh = pa_r >>> MU_SHIFT;
        pb_sh = pb_r >>> MU_SHIFT;
        a_sum = $signed({{(SW-DW){a_r[DW-1]}}, a_r}) + $signed({{(SW-PW){pa_sh[PW-1]}}, pa_sh});
        b_sum = $signed({{(SW-DW){b_r[DW-1]}}, b_r}) + $signed({{(SW-PW){pb_sh[PW-1]}}, pb_sh});
        // One extra bit so that |-2^(DW-1)| is representable and never "near".
        e_ext = $signed({e_r[DW-1], e_r});
        e_abs = e_ext[DW] ? -e_ext : e_ext;
        near  = (e_abs <= $signed((DW+1)'(CONV_TH)));
        if (!near)
            cnt_next = '0;
        else if (cnt_r == CW'(CONV_CNT))
            cnt_next = cnt_r;
        else
            cnt_next = cnt_r + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            x_r     <= '0;
            yl_r    <= '0;
            y_r     <= '0;
            yh_r    <= '0;
            e_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            pa_r    <= '0;
            pb_r    <= '0;
            cnt_r   <= '0;
            conv_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x_r   <= bus.in_x_last;
                        yl_r  <= bus.in_y_last;
                        y_r   <= bus.in_y_current;
                        yh_r  <= bus.in_y_hat_current;
                        state <= S_ERR;
                    end
                end
                S_ERR: begin
                    e_r   <= sat(diff);
                    state <= S_MUL;
                end
                S_MUL: begin
                    pa_r  <= e_w * yl_w;
                    pb_r  <= e_w * x_w;
                    state <= S_UPD;
                end
                S_UPD: begin
                    if (adapt) begin
                        a_r <= sat(a_sum);
                        b_r <= sat(b_sum);
                    end
                    cnt_r   <= cnt_next;
                    conv_r  <= (cnt_next == CW'(CONV_CNT));
                    valid_r <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_a_hat = a_r;
    assign bus.out_b_hat = b_r;
    assign bus.out_err   = e_r;
    assign bus.out_valid = valid_r;
    assign bus.converged = conv_r;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_lms_weight_update.sv
// ----------------------------------------------------------------------------
// tb_lms_weight_update
//   Self-checking bench for lms_weight_update (DW=8, MU_SHIFT=3, CONV_TH=1,
//   CONV_CNT=8). Expected results come from an integer model of the LMS
//   update rules and are queued per accepted sample.
//   Optional feature macro: LMS_FREEZE_EN (adds the freeze scenario).
// ----------------------------------------------------------------------------
module tb_lms_weight_update;
    localparam int W  = 8;
    localparam int EW = 3 * W + 1;

    logic clk;
    logic rst;

    lms_weight_update_if #(.DW(W)) bus ();

    lms_weight_update #(
        .DW(W), .MU_SHIFT(3), .CONV_TH(1), .CONV_CNT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [EW-1:0] exp_q[$];   // {err, a_hat, b_hat, converged}

    task automatic check_val(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_a = 0, m_b = 0, m_cnt = 0;
    bit  m_freeze = 1'b0;

    function automatic int clamp8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Mathematical floor of v / d for d > 0.
    function automatic int floor_div(input int v, input int d);
        int q;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_push(input int x, input int yl, input int y, input int yh);
        int e, ae;
        logic [W-1:0] ev, av, bv;
        e = clamp8(y - yh);
        if (!m_freeze) begin
            m_a = clamp8(m_a + floor_div(e * yl, 8));
            m_b = clamp8(m_b + floor_div(e * x, 8));
        end
        ae = (e < 0) ? -e : e;
        if (ae <= 1) m_cnt = (m_cnt >= 8) ? 8 : m_cnt + 1;
        else         m_cnt = 0;
        ev = e[W-1:0];
        av = m_a[W-1:0];
        bv = m_b[W-1:0];
        exp_q.push_back({ev, av, bv, (m_cnt == 8)});
    endtask

    task automatic model_reset();
        m_a = 0;
        m_b = 0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_data(input int x, input int yl, input int y, input int yh);
        bus.in_x_last        = x[W-1:0];
        bus.in_y_last        = yl[W-1:0];
        bus.in_y_current     = y[W-1:0];
        bus.in_y_hat_current = yh[W-1:0];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge after the result was checked.
    task automatic send(input string tag, input int x, input int yl, input int y, input int yh);
        int n;
        int k;
        bit found;
        logic [EW-1:0] e;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_ready"}, int'(bus.in_ready), 1);
        drive_data(x, yl, y, yh);
        model_push(x, yl, y, yh);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 12) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) found = 1'b1;
        end
        // Negedge k lies after edge k-1; results are due after edge 3.
        check_val({tag, "_latency"}, k, 4);
        if (found && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_err"},  int'(bus.out_err),   int'($signed(e[EW-1 -: W])));
            check_val({tag, "_a"},    int'(bus.out_a_hat), int'($signed(e[EW-1-W -: W])));
            check_val({tag, "_b"},    int'(bus.out_b_hat), int'($signed(e[W:1])));
            check_val({tag, "_conv"}, int'(bus.converged), int'(e[0]));
            @(negedge clk);
            check_val({tag, "_pulse"}, int'(bus.out_valid), 0);
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int acc, last, pulses, yv, ovs;
        logic [EW-1:0] e;
        rst = 1'b0;
        bus.in_valid = 1'b0;
`ifdef LMS_FREEZE_EN
        bus.freeze = 1'b0;
`endif
        drive_data(0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_ready", int'(bus.in_ready),  1);
        check_val("rst_a",     int'(bus.out_a_hat), 0);
        check_val("rst_b",     int'(bus.out_b_hat), 0);
        check_val("rst_err",   int'(bus.out_err),   0);
        check_val("rst_valid", int'(bus.out_valid), 0);
        check_val("rst_conv",  int'(bus.converged), 0);
        check_val("rst_state", int'(bus.fsm_state), 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic step from zero coefficients
        send("basic", 2, 0, 4, 0);
        check_val("basic_b_abs", int'(bus.out_b_hat), 1);
        check_val("basic_a_abs", int'(bus.out_a_hat), 0);

        // Saturation of error and coefficients
        send("sat", 127, -128, 127, -128);
        check_val("sat_b_abs", int'(bus.out_b_hat), 127);
        check_val("sat_a_abs", int'(bus.out_a_hat), -128);
        send("sat_neg", -128, -128, -128, 127);

        // Floor rounding of a small negative step
        do_reset();
        send("floor", 1, 1, 0, 1);
        check_val("floor_a_abs", int'(bus.out_a_hat), -1);
        check_val("floor_b_abs", int'(bus.out_b_hat), -1);

        // Convergence run, then a larger error drops it
        do_reset();
        for (int i = 0; i < 8; i++) begin
            yv = rnd8();
            send("conv", rnd8(), rnd8(), yv, yv);
        end
        check_val("conv_after8", int'(bus.converged), 1);
        send("conv_drop", 5, 3, 2, 0);
        check_val("conv_dropped", int'(bus.converged), 0);

        // Randomized samples, half of them close to convergence
        for (int i = 0; i < 60; i++) begin
            yv = rnd8();
            if ($urandom_range(0, 1) == 1)
                send("rand", rnd8(), rnd8(), yv, clamp8(yv + int'($urandom_range(0, 2)) - 1));
            else
                send("rand", rnd8(), rnd8(), yv, rnd8());
        end

        // Held in_valid: one acceptance every 4 cycles
        do_reset();
        drive_data(37, -21, 90, -40);
        bus.in_valid = 1'b1;
        acc = 0;
        last = -1;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus.out_valid) pulses++;
            if (bus.in_ready) begin
                if (last >= 0) check_val("bp_gap", c - last, 4);
                last = c;
                acc++;
                model_push(37, -21, 90, -40);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (bus.out_valid) pulses++;
        check_val("bp_accepts", acc, 4);
        check_val("bp_pulses", pulses, 4);
        e = '0;
        while (exp_q.size() > 0) e = exp_q.pop_front();
        check_val("bp_a", int'(bus.out_a_hat), int'($signed(e[EW-1-W -: W])));
        check_val("bp_b", int'(bus.out_b_hat), int'($signed(e[W:1])));
        check_val("bp_err", int'(bus.out_err), int'($signed(e[EW-1 -: W])));
        @(negedge clk);

        // Reset while the sample sits in MUL
        drive_data(100, 100, 120, -100);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mrst_a",     int'(bus.out_a_hat), 0);
        check_val("mrst_b",     int'(bus.out_b_hat), 0);
        check_val("mrst_err",   int'(bus.out_err),   0);
        check_val("mrst_conv",  int'(bus.converged), 0);
        check_val("mrst_ready", int'(bus.in_ready),  1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        ovs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) ovs++;
        end
        check_val("mrst_no_valid", ovs, 0);
        send("post_rst", 2, 0, 4, 0);

`ifdef LMS_FREEZE_EN
        // Frozen coefficients, error and pulse still update
        do_reset();
        bus.freeze = 1'b1;
        m_freeze = 1'b1;
        send("freeze", 2, 0, 4, 0);
        check_val("freeze_err", int'(bus.out_err), 4);
        check_val("freeze_b",   int'(bus.out_b_hat), 0);
        bus.freeze = 1'b0;
        m_freeze = 1'b0;
        send("unfreeze", 2, 0, 4, 0);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
